sram64_arbiter: RTL and testbench

SRAM64_ARBITER -- requirements
Module: sram64_arbiter

---
 rtl/sram64_arbiter_pkg.sv | 14 +
 rtl/sram64_arbiter.sv | 119 +++++++++++
 tb/tb_sram64_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram64_arbiter_pkg.sv
// Shared pipeline definitions used by the SRAM arbiter and its neighbours.
package sram64_arbiter_pkg;

  // Which requester owns the SRAM read currently in flight.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Consecutive data grants allowed while a fetch is waiting.
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/sram64_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one 64-bit
// single-port SRAM with 1-cycle read latency. Data has priority, but
// a waiting fetch wins once data has been granted STARVE_MAX times
// in a row.
module sram64_arbiter
  import sram64_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch port
  input  logic              if_req,
  input  logic [63:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [63:0]       if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [7:0]        d_wea,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  // SRAM port
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wea,
  output logic [63:0]       sram_dina,
  input  logic [63:0]       sram_douta
);

  localparam int                CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  owner_e           owner_q, owner_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             d_write;

  // Byte-offset and high address bits never reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr, d_addr};

  // Grant selection: data first unless fetch has waited long enough.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    // NOTE: grants are combinational, so they are gated by rst_n directly to
    // keep the SRAM idle while reset is held.
    if (rst_n) begin
      if (if_req && (!d_req || (starve_cnt == CNT_MAX))) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // SRAM drive for the granted requester; idle cycles drive zeros.
  always_comb begin
    d_write   = d_gnt && d_we;
    sram_en   = if_gnt || d_gnt;
    sram_addr = '0;
    sram_wea  = '0;
    sram_dina = '0;
    if (if_gnt) begin
      sram_addr = if_addr[ADDR_W+2:3];
    end else if (d_gnt) begin
      sram_addr = d_addr[ADDR_W+2:3];
    end
    if (d_write) begin
      sram_wea  = d_wea;
      sram_dina = d_wdata;
    end
  end

  // Next read owner and starvation count.
  always_comb begin
    owner_nxt  = OWN_NONE;
    starve_nxt = starve_cnt;
    if (if_gnt) begin
      owner_nxt = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_nxt = OWN_D;
    end
    if (!if_req || if_gnt) begin
      starve_nxt = '0;
    end else if (d_gnt && (starve_cnt != CNT_MAX)) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  // State registers; reset discards any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      owner_q    <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Read return: the recorded owner sees the SRAM word, the other sees 0.
  always_comb begin
    if_rvalid = (owner_q == OWN_IF);
    d_rvalid  = (owner_q == OWN_D);
    if_rdata  = if_rvalid ? sram_douta : '0;
    d_rdata   = d_rvalid  ? sram_douta : '0;
  end

endmodule

// File: tb/tb_sram64_arbiter.sv
// Directed self-checking bench for sram64_arbiter. ADDR_W is set to 9 so
// that the fetch at 0x1008 maps to word 1 with its upper bits dropped.
module tb_sram64_arbiter;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req;
  logic [63:0]       if_addr;
  logic              if_gnt, if_rvalid;
  logic [63:0]       if_rdata;
  logic              d_req, d_we;
  logic [63:0]       d_addr;
  logic [7:0]        d_wea;
  logic [63:0]       d_wdata;
  logic              d_gnt, d_rvalid;
  logic [63:0]       d_rdata;
  logic              sram_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wea;
  logic [63:0]       sram_dina;
  logic [63:0]       sram_douta;

  int tests  = 0;
  int failed = 0;

  sram64_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wea      (d_wea),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .sram_en    (sram_en),
    .sram_addr  (sram_addr),
    .sram_wea   (sram_wea),
    .sram_dina  (sram_dina),
    .sram_douta (sram_douta)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to the next falling edge, then settle the combinational outputs.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0; if_addr = '0;
    d_req   = 1'b0; d_we    = 1'b0; d_addr = '0;
    d_wea   = '0;   d_wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".if_gnt"},    {63'd0, if_gnt},    64'd0);
    check({tag, ".d_gnt"},     {63'd0, d_gnt},     64'd0);
    check({tag, ".if_rvalid"}, {63'd0, if_rvalid}, 64'd0);
    check({tag, ".d_rvalid"},  {63'd0, d_rvalid},  64'd0);
    check({tag, ".if_rdata"},  if_rdata,           64'd0);
    check({tag, ".d_rdata"},   d_rdata,            64'd0);
    check({tag, ".sram_en"},   {63'd0, sram_en},   64'd0);
    check({tag, ".sram_addr"}, 64'(sram_addr),     64'd0);
    check({tag, ".sram_wea"},  64'(sram_wea),      64'd0);
    check({tag, ".sram_dina"}, sram_dina,          64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    sram_douta = 64'hDEAD_BEEF_0000_0001;
    idle_inputs();
    // Requests during reset must not reach the SRAM.
    if_req  = 1'b1; if_addr = 64'h1008;
    d_req   = 1'b1; d_we = 1'b1; d_wea = 8'hFF; d_wdata = 64'h55;
    next_cycle(); settle();
    check_all_zero("reset");
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    settle();
    check_all_zero("post_reset");

    // Single fetch at 0x1008: word 0x201, upper bit dropped at ADDR_W=9.
    next_cycle();
    if_req = 1'b1; if_addr = 64'h1008;
    settle();
    check("fetch.if_gnt",    {63'd0, if_gnt},  64'd1);
    check("fetch.d_gnt",     {63'd0, d_gnt},   64'd0);
    check("fetch.sram_en",   {63'd0, sram_en}, 64'd1);
    check("fetch.sram_addr", 64'(sram_addr),   64'd1);
    check("fetch.sram_wea",  64'(sram_wea),    64'd0);
    next_cycle();
    idle_inputs();
    sram_douta = 64'h1111_2222_3333_4444;
    settle();
    check("fetch.if_rvalid", {63'd0, if_rvalid}, 64'd1);
    check("fetch.if_rdata",  if_rdata,           64'h1111_2222_3333_4444);
    check("fetch.d_rvalid",  {63'd0, d_rvalid},  64'd0);
    check("fetch.d_rdata",   d_rdata,            64'd0);
    check("fetch.idle_en",   {63'd0, sram_en},   64'd0);
    next_cycle(); settle();
    check("fetch.rvalid_drop", {63'd0, if_rvalid}, 64'd0);
    check("fetch.rdata_drop",  if_rdata,           64'd0);

    // Simultaneous data read at 0x20 and fetch at 0x0.
    next_cycle();
    d_req = 1'b1; d_addr = 64'h20;
    if_req = 1'b1; if_addr = 64'h0;
    settle();
    check("simul.d_gnt",     {63'd0, d_gnt},  64'd1);
    check("simul.if_gnt",    {63'd0, if_gnt}, 64'd0);
    check("simul.sram_addr", 64'(sram_addr),  64'd4);
    next_cycle();
    d_req = 1'b0;
    sram_douta = 64'hA5A5_0000_0000_0020;
    settle();
    check("simul.d_rvalid",  {63'd0, d_rvalid}, 64'd1);
    check("simul.d_rdata",   d_rdata,           64'hA5A5_0000_0000_0020);
    check("simul.if_rdata0", if_rdata,          64'd0);
    check("simul.if_gnt2",   {63'd0, if_gnt},   64'd1);
    check("simul.addr2",     64'(sram_addr),    64'd0);
    next_cycle();
    if_req = 1'b0;
    sram_douta = 64'h5A5A_0000_0000_0000;
    settle();
    check("simul.if_rvalid", {63'd0, if_rvalid}, 64'd1);
    check("simul.if_rdata",  if_rdata,           64'h5A5A_0000_0000_0000);
    check("simul.d_rvalid2", {63'd0, d_rvalid},  64'd0);

    // Read at 0x48 followed directly by a partial store at 0x40.
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h48;
    settle();
    check("rw.rd_gnt",  {63'd0, d_gnt},  64'd1);
    check("rw.rd_addr", 64'(sram_addr),  64'd9);
    next_cycle();
    d_we = 1'b1; d_addr = 64'h40; d_wea = 8'h0C; d_wdata = 64'hAABB_0000;
    sram_douta = 64'hCAFE_0000_0000_0048;
    settle();
    check("rw.d_rvalid",   {63'd0, d_rvalid}, 64'd1);
    check("rw.d_rdata",    d_rdata,           64'hCAFE_0000_0000_0048);
    check("rw.wr_gnt",     {63'd0, d_gnt},    64'd1);
    check("rw.sram_en",    {63'd0, sram_en},  64'd1);
    check("rw.sram_addr",  64'(sram_addr),    64'd8);
    check("rw.sram_wea",   64'(sram_wea),     64'h0C);
    check("rw.sram_dina",  sram_dina,         64'hAABB_0000);
    // Write with no byte enables: granted, nothing written.
    next_cycle();
    d_wea = 8'h00; d_addr = 64'h50;
    settle();
    check("store.no_rvalid", {63'd0, d_rvalid}, 64'd0);
    check("nop.d_gnt",       {63'd0, d_gnt},    64'd1);
    check("nop.sram_wea",    64'(sram_wea),     64'd0);
    next_cycle();
    idle_inputs();
    settle();
    check("nop.no_rvalid",   {63'd0, d_rvalid}, 64'd0);
    check("nop.no_if_rv",    {63'd0, if_rvalid}, 64'd0);

    // Starvation: both requesters held; pattern D D D D I repeats.
    next_cycle();
    d_req = 1'b1; d_addr = 64'h100;
    if_req = 1'b1; if_addr = 64'h200;
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("starve[%0d].if_gnt", i), {63'd0, if_gnt}, (i % 5 == 4) ? 64'd1 : 64'd0);
      check($sformatf("starve[%0d].d_gnt", i),  {63'd0, d_gnt},  (i % 5 == 4) ? 64'd0 : 64'd1);
      if (i > 0) begin
        check($sformatf("starve[%0d].if_rv", i), {63'd0, if_rvalid}, (i % 5 == 0) ? 64'd1 : 64'd0);
        check($sformatf("starve[%0d].d_rv", i),  {63'd0, d_rvalid},  (i % 5 == 0) ? 64'd0 : 64'd1);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Reset dropped the cycle after a fetch grant discards the read.
    if_req = 1'b1; if_addr = 64'h8;
    settle();
    check("rst_mid.if_gnt", {63'd0, if_gnt}, 64'd1);
    next_cycle();
    idle_inputs();
    rst_n = 1'b0;
    sram_douta = 64'hFFFF_FFFF_FFFF_FFFF;
    settle();
    check_all_zero("rst_mid.in_reset");
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_all_zero($sformatf("rst_mid.after[%0d]", i));
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
